fetch_stage: RTL and testbench

//   Instruction-fetch stage of the DATAPATH. Owns the program counter and drives the

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory address and latches
//    the returned word into the IF/ID register consumed by decode.
// Latency: word at address A appears on ifid_instr one clock edge after PC==A.
// Backpressure: stall holds PC and IF/ID; br_taken/jump redirect the PC even
//    under stall; flush loads a NOP bubble.
// Ports:
//    clk, rst            clock (rising edge), asynchronous active-high reset
//    stall, flush        hazard-unit hold / bubble insert
//    br_taken, br_target resolved branch redirect (byte address)
//    jump, jump_idx      J-format redirect, instr[25:0] of the jump
//    imem_addr/imem_data instruction memory address (= PC) / combinational data
//    ifid_instr/pc4/valid  IF/ID pipeline register
//    fetch_cnt           saturating count of valid IF/ID loads since reset
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             jump,
   input  logic [25:0]      jump_idx,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc4,
   output logic             ifid_valid,
   output logic [CNT_W-1:0] fetch_cnt
);

   // Word alignment is enforced here so the PC low bits can never be non-zero.
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] PC_INIT    = RESET_PC & ALIGN_MASK;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic        ifid_load;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;          // wraps naturally mod 2^32
   assign ifid_load = !flush && !stall;

   // Redirects take precedence over stall: a stall raised by a wrong-path
   // instruction must not swallow a resolved branch or jump.
   always_comb begin
      pc_next = pc_plus4;
      if (br_taken)
         pc_next = br_target & ALIGN_MASK;
      else if (jump)
         pc_next = {ifid_pc4[31:28], jump_idx, 2'b00};
      else if (stall)
         pc_next = pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= PC_INIT;
      else
         pc <= pc_next;
   end

   // IF/ID register. A redirect without flush still captures the current word
   // so the controller can use it as a delay slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_instr <= 32'd0;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
      end else if (flush) begin
         ifid_instr <= 32'd0;
         ifid_pc4   <= 32'd0;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_instr <= imem_data;
         ifid_pc4   <= pc_plus4;
         ifid_valid <= 1'b1;
      end
   end

   // Saturating: stops at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_cnt <= '0;
      else if (ifid_load && (fetch_cnt != {CNT_W{1'b1}}))
         fetch_cnt <= fetch_cnt + CNT_ONE;
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_idx = 26'd0;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [31:0] fetch_cnt;

   // Second instance: wrap-around reset PC and a narrow counter for saturation.
   logic        rst2 = 1'b1;
   logic [31:0] imem_addr2, imem_data2;
   logic [31:0] ifid_instr2, ifid_pc42;
   logic        ifid_valid2;
   logic [1:0]  fetch_cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory contents: word i holds 0xAB00_0000 + i.
   function automatic logic [31:0] memw(input logic [31:0] a);
      return 32'hAB00_0000 + {2'b00, a[31:2]};
   endfunction

   assign imem_data  = memw(imem_addr);
   assign imem_data2 = memw(imem_addr2);

   fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_idx(jump_idx),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
      .fetch_cnt(fetch_cnt)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst2), .stall(1'b0), .flush(1'b0),
      .br_taken(1'b0), .br_target(32'd0), .jump(1'b0), .jump_idx(26'd0),
      .imem_addr(imem_addr2), .imem_data(imem_data2),
      .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42), .ifid_valid(ifid_valid2),
      .fetch_cnt(fetch_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic valid, input logic [31:0] cnt);
      check({tag, ".pc"},    imem_addr, pc);
      check({tag, ".instr"}, ifid_instr, instr);
      check({tag, ".pc4"},   ifid_pc4, pc4);
      check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
      check({tag, ".cnt"},   fetch_cnt, cnt);
   endtask

   initial begin
      // 1: reset state, then three free-running fetches
      #1;
      check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(3);
      check_ifid("run3", 32'hC, 32'hAB00_0002, 32'hC, 1'b1, 32'd3);

      // 2: stall at PC=0x8 (re-reset, run two edges first)
      #2 rst = 1'b1;
      #1;
      check_ifid("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(2);
      check_ifid("run2", 32'h8, 32'hAB00_0001, 32'h8, 1'b1, 32'd2);
      stall = 1'b1;
      tick(2);
      check_ifid("stall", 32'h8, 32'hAB00_0001, 32'h8, 1'b1, 32'd2);
      stall = 1'b0;
      tick(1);
      check_ifid("unstall", 32'hC, 32'hAB00_0002, 32'hC, 1'b1, 32'd3);

      // 3: branch with flush to 0x40, then fetch from target
      br_taken = 1'b1; br_target = 32'h40; flush = 1'b1;
      tick(1);
      check_ifid("br_flush", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
      br_taken = 1'b0; flush = 1'b0;
      tick(1);
      check_ifid("br_tgt", 32'h44, 32'hAB00_0010, 32'h44, 1'b1, 32'd4);

      // 4: branch without flush (delay slot latched), then J-format jump
      br_taken = 1'b1; br_target = 32'h1000_0000;
      tick(1);
      check_ifid("br_dslot", 32'h1000_0000, 32'hAB00_0011, 32'h48, 1'b1, 32'd5);
      br_taken = 1'b0;
      tick(1);
      check_ifid("pre_jump", 32'h1000_0004, 32'hAF00_0000, 32'h1000_0004, 1'b1, 32'd6);
      jump = 1'b1; jump_idx = 26'h10; flush = 1'b1;
      tick(1);
      check_ifid("jump", 32'h1000_0040, 32'h0, 32'h0, 1'b0, 32'd6);
      jump = 1'b0; flush = 1'b0;
      tick(1);
      check_ifid("jump_tgt", 32'h1000_0044, 32'hAF00_0010, 32'h1000_0044, 1'b1, 32'd7);

      // 5: branch (unaligned target) + jump + stall together
      br_taken = 1'b1; br_target = 32'h43; jump = 1'b1; jump_idx = 26'h3FF; stall = 1'b1;
      tick(1);
      check_ifid("br_prio", 32'h40, 32'hAF00_0010, 32'h1000_0044, 1'b1, 32'd7);
      br_taken = 1'b0; jump = 1'b0; stall = 1'b0;

      // 6: PC wrap from 0xFFFF_FFFC, counter saturation, mid-cycle reset
      check("wrap.rst_pc", imem_addr2, 32'hFFFF_FFFC);
      rst2 = 1'b0;
      tick(1);
      check("wrap.pc",    imem_addr2, 32'h0);
      check("wrap.pc4",   ifid_pc42, 32'h0);
      check("wrap.instr", ifid_instr2, 32'hEAFF_FFFF);
      check("wrap.cnt",   {30'd0, fetch_cnt2}, 32'd1);
      tick(3);
      check("sat.pc",  imem_addr2, 32'hC);
      check("sat.cnt", {30'd0, fetch_cnt2}, 32'd3);
      #2 rst2 = 1'b1;
      #1;
      check("arst.pc",    imem_addr2, 32'hFFFF_FFFC);
      check("arst.instr", ifid_instr2, 32'h0);
      check("arst.pc4",   ifid_pc42, 32'h0);
      check("arst.valid", {31'd0, ifid_valid2}, 32'd0);
      check("arst.cnt",   {30'd0, fetch_cnt2}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
